// File: rtl/exe_mem_reg_if.sv
// EXE->MEM pipeline bus: EXE-stage inputs, stall/flush/fault-clear controls, and registered MEM-stage outputs.
// The master modport drives the EXE side. The slave modport is the pipeline register.
interface exe_mem_reg_if;
  logic        freeze;
  logic        flush;
  logic        fault_clr;
  logic        WB_EN_in;
  logic        Mem_R_EN_in;
  logic        Mem_W_EN_in;
  logic [31:0] ALU_res_in;
  logic [31:0] Val_Rm_in;
  logic [3:0]  Dest_in;

  logic        WB_EN;
  logic        Mem_R_EN;
  logic        Mem_W_EN;
  logic [31:0] ALU_res;
  logic [31:0] Val_Rm;
  logic [3:0]  Dest;
  logic        valid;
  logic        mem_fault;
  logic [31:0] fault_addr;
  logic [15:0] mem_ops;

  modport master (
    output freeze, flush, fault_clr,
    output WB_EN_in, Mem_R_EN_in, Mem_W_EN_in, ALU_res_in, Val_Rm_in, Dest_in,
    input  WB_EN, Mem_R_EN, Mem_W_EN, ALU_res, Val_Rm, Dest,
    input  valid, mem_fault, fault_addr, mem_ops
  );

  modport slave (
    input  freeze, flush, fault_clr,
    input  WB_EN_in, Mem_R_EN_in, Mem_W_EN_in, ALU_res_in, Val_Rm_in, Dest_in,
    output WB_EN, Mem_R_EN, Mem_W_EN, ALU_res, Val_Rm, Dest,
    output valid, mem_fault, fault_addr, mem_ops
  );
endinterface

// File: rtl/exe_mem_reg.sv
// EXE/MEM pipeline register. It checks each data-memory access against the legal address window,
// suppresses out-of-window or misaligned accesses, records the first faulting address, and counts accesses passed to MEM.
module exe_mem_reg #(
  parameter int unsigned DM_BASE  = 1024,
  parameter int unsigned DM_WORDS = 64
) (
  input logic           clk,
  input logic           rst,
  exe_mem_reg_if.slave  bus
);

  // 33-bit bounds so DM_BASE + 4*DM_WORDS cannot wrap.
  localparam logic [32:0] DmLow  = 33'(DM_BASE);
  localparam logic [32:0] DmHigh = 33'(DM_BASE) + 33'(DM_WORDS) * 33'd4;

  logic        wbEn_q,      wbEn_d;
  logic        memREn_q,    memREn_d;
  logic        memWEn_q,    memWEn_d;
  logic [31:0] aluRes_q,    aluRes_d;
  logic [31:0] valRm_q,     valRm_d;
  logic [3:0]  dest_q,      dest_d;
  logic        valid_q,     valid_d;
  logic        memFault_q,  memFault_d;
  logic [31:0] faultAddr_q, faultAddr_d;
  logic [15:0] memOps_q,    memOps_d;

  logic [32:0] addrExt;
  logic        memReq;
  logic        belowWindow;
  logic        aboveWindow;
  logic        misaligned;
  logic        illegal;

  assign addrExt     = {1'b0, bus.ALU_res_in};
  assign memReq      = bus.Mem_R_EN_in | bus.Mem_W_EN_in;
  assign belowWindow = addrExt < DmLow;
  assign aboveWindow = addrExt >= DmHigh;
  assign misaligned  = bus.ALU_res_in[1:0] != 2'b00;
  assign illegal     = memReq & ((bus.Mem_R_EN_in & bus.Mem_W_EN_in)
                                 | belowWindow | aboveWindow | misaligned);

  always_comb begin
    wbEn_d      = wbEn_q;
    memREn_d    = memREn_q;
    memWEn_d    = memWEn_q;
    aluRes_d    = aluRes_q;
    valRm_d     = valRm_q;
    dest_d      = dest_q;
    valid_d     = valid_q;
    memFault_d  = memFault_q;
    faultAddr_d = faultAddr_q;
    memOps_d    = memOps_q;

    if (!bus.freeze) begin
      if (bus.fault_clr) begin
        memFault_d  = 1'b0;
        faultAddr_d = 32'd0;
      end

      if (bus.flush) begin
        wbEn_d   = 1'b0;
        memREn_d = 1'b0;
        memWEn_d = 1'b0;
        aluRes_d = 32'd0;
        valRm_d  = 32'd0;
        dest_d   = 4'd0;
        valid_d  = 1'b0;
      end else begin
        wbEn_d   = bus.WB_EN_in;
        memREn_d = bus.Mem_R_EN_in;
        memWEn_d = bus.Mem_W_EN_in;
        aluRes_d = bus.ALU_res_in;
        valRm_d  = bus.Val_Rm_in;
        dest_d   = bus.Dest_in;
        valid_d  = 1'b1;

        // A suppressed load must not write back. A suppressed store keeps its WB_EN.
        if (illegal) begin
          memREn_d = 1'b0;
          memWEn_d = 1'b0;
          wbEn_d   = bus.Mem_R_EN_in ? 1'b0 : bus.WB_EN_in;
          if (!memFault_q || bus.fault_clr) begin
            memFault_d  = 1'b1;
            faultAddr_d = bus.ALU_res_in;
          end
        end else if (memReq && memOps_q != 16'hFFFF) begin
          memOps_d = memOps_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbEn_q      <= 1'b0;
      memREn_q    <= 1'b0;
      memWEn_q    <= 1'b0;
      aluRes_q    <= 32'd0;
      valRm_q     <= 32'd0;
      dest_q      <= 4'd0;
      valid_q     <= 1'b0;
      memFault_q  <= 1'b0;
      faultAddr_q <= 32'd0;
      memOps_q    <= 16'd0;
    end else begin
      wbEn_q      <= wbEn_d;
      memREn_q    <= memREn_d;
      memWEn_q    <= memWEn_d;
      aluRes_q    <= aluRes_d;
      valRm_q     <= valRm_d;
      dest_q      <= dest_d;
      valid_q     <= valid_d;
      memFault_q  <= memFault_d;
      faultAddr_q <= faultAddr_d;
      memOps_q    <= memOps_d;
    end
  end

  assign bus.WB_EN      = wbEn_q;
  assign bus.Mem_R_EN   = memREn_q;
  assign bus.Mem_W_EN   = memWEn_q;
  assign bus.ALU_res    = aluRes_q;
  assign bus.Val_Rm     = valRm_q;
  assign bus.Dest       = dest_q;
  assign bus.valid      = valid_q;
  assign bus.mem_fault  = memFault_q;
  assign bus.fault_addr = faultAddr_q;
  assign bus.mem_ops    = memOps_q;

endmodule

// File: tb/tb_exe_mem_reg.sv
// Directed bench for exe_mem_reg with DM_BASE=1024 and DM_WORDS=64, so the legal window is [1024,1280).
// Every expected value below is hand-computed.
module tb_exe_mem_reg;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  exe_mem_reg_if bus ();

  exe_mem_reg #(
    .DM_BASE  (1024),
    .DM_WORDS (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag,
                          input logic wb, input logic r, input logic w,
                          input logic [31:0] alu, input logic [3:0] dest, input logic vld,
                          input logic flt, input logic [31:0] faddr, input logic [15:0] ops);
    checkOutput({tag, ".WB_EN"},      32'(bus.WB_EN),      32'(wb));
    checkOutput({tag, ".Mem_R_EN"},   32'(bus.Mem_R_EN),   32'(r));
    checkOutput({tag, ".Mem_W_EN"},   32'(bus.Mem_W_EN),   32'(w));
    checkOutput({tag, ".ALU_res"},    bus.ALU_res,         alu);
    checkOutput({tag, ".Dest"},       32'(bus.Dest),       32'(dest));
    checkOutput({tag, ".valid"},      32'(bus.valid),      32'(vld));
    checkOutput({tag, ".mem_fault"},  32'(bus.mem_fault),  32'(flt));
    checkOutput({tag, ".fault_addr"}, bus.fault_addr,      faddr);
    checkOutput({tag, ".mem_ops"},    32'(bus.mem_ops),    32'(ops));
  endtask

  task automatic applyStimulus(input logic frz, input logic fls, input logic clr,
                               input logic wb, input logic r, input logic w,
                               input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest);
    bus.freeze      = frz;
    bus.flush       = fls;
    bus.fault_clr   = clr;
    bus.WB_EN_in    = wb;
    bus.Mem_R_EN_in = r;
    bus.Mem_W_EN_in = w;
    bus.ALU_res_in  = alu;
    bus.Val_Rm_in   = val;
    bus.Dest_in     = dest;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    applyStimulus(0, 0, 0, 1, 1, 0, 32'd1032, 32'd9, 4'd7);

    // Reset holds everything at zero and ignores inputs across clock edges.
    #2;
    checkAll("reset0", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();
    stepCycle();
    checkAll("resetHold", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("resetHold.Val_Rm", bus.Val_Rm, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 1, 1, 0, 32'd1032, 32'd0, 4'd5);
    stepCycle();
    checkAll("load", 1, 1, 0, 32'd1032, 4'd5, 1, 0, 0, 16'd1);

    // Freeze for three cycles with changing inputs. A flush during the freeze is ignored.
    applyStimulus(1, 0, 0, 0, 0, 1, 32'd1040, 32'd3, 4'd2);
    stepCycle();
    checkAll("freeze1", 1, 1, 0, 32'd1032, 4'd5, 1, 0, 0, 16'd1);
    applyStimulus(1, 1, 1, 1, 0, 1, 32'd1044, 32'd4, 4'd3);
    stepCycle();
    checkAll("freeze2", 1, 1, 0, 32'd1032, 4'd5, 1, 0, 0, 16'd1);
    applyStimulus(1, 0, 0, 0, 1, 0, 32'd7, 32'd5, 4'd4);
    stepCycle();
    checkAll("freeze3", 1, 1, 0, 32'd1032, 4'd5, 1, 0, 0, 16'd1);

    applyStimulus(0, 0, 0, 0, 0, 1, 32'd1026, 32'hAA, 4'd0);
    stepCycle();
    checkAll("misalignedStore", 0, 0, 0, 32'd1026, 4'd0, 1, 1, 32'd1026, 16'd1);
    checkOutput("misalignedStore.Val_Rm", bus.Val_Rm, 32'hAA);

    applyStimulus(0, 0, 0, 1, 1, 0, 32'd1000, 32'd0, 4'd3);
    stepCycle();
    checkAll("lowLoad", 0, 0, 0, 32'd1000, 4'd3, 1, 1, 32'd1026, 16'd1);

    applyStimulus(0, 0, 1, 0, 0, 1, 32'd2000, 32'd0, 4'd1);
    stepCycle();
    checkAll("clrAndFault", 0, 0, 0, 32'd2000, 4'd1, 1, 1, 32'd2000, 16'd1);

    applyStimulus(0, 0, 1, 1, 0, 0, 32'h1234_5677, 32'd0, 4'd6);
    stepCycle();
    checkAll("clrOnly", 1, 0, 0, 32'h1234_5677, 4'd6, 1, 0, 0, 16'd1);

    // Window boundaries: first word, last word, one past the end, and read+write together.
    applyStimulus(0, 0, 0, 0, 0, 1, 32'd1024, 32'd11, 4'd0);
    stepCycle();
    checkAll("store1024", 0, 0, 1, 32'd1024, 4'd0, 1, 0, 0, 16'd2);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'd1276, 32'd12, 4'd0);
    stepCycle();
    checkAll("store1276", 0, 0, 1, 32'd1276, 4'd0, 1, 0, 0, 16'd3);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'd1280, 32'd13, 4'd0);
    stepCycle();
    checkAll("store1280", 0, 0, 0, 32'd1280, 4'd0, 1, 1, 32'd1280, 16'd3);
    applyStimulus(0, 0, 0, 1, 1, 1, 32'd1024, 32'd14, 4'd9);
    stepCycle();
    checkAll("readWrite", 0, 0, 0, 32'd1024, 4'd9, 1, 1, 32'd1280, 16'd3);

    applyStimulus(0, 1, 0, 1, 0, 1, 32'd1028, 32'd15, 4'd8);
    stepCycle();
    checkAll("flush", 0, 0, 0, 0, 0, 0, 1, 32'd1280, 16'd3);
    checkOutput("flush.Val_Rm", bus.Val_Rm, 32'd0);

    // Bring mem_ops up to 7 with four legal loads.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 0, 32'd1028 + 32'(4 * i), 32'd0, 4'd2);
      stepCycle();
    end
    checkAll("loads", 1, 1, 0, 32'd1040, 4'd2, 1, 1, 32'd1280, 16'd7);

    // Assert reset mid-cycle. Outputs must clear before the next rising edge.
    #2;
    rst = 1'b0;
    #1;
    checkAll("asyncReset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1, 32'd1100, 32'd0, 4'd4);
    stepCycle();
    checkAll("postReset", 0, 0, 1, 32'd1100, 4'd4, 1, 0, 0, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_mem_reg.md
EXE_MEM_REG -- requirements
Module: exe_mem_reg

Interface
REQ-001 Parameter: DM_BASE, 1024, byte address of data-memory word 0.
REQ-002 Parameter: DM_WORDS, 64, number of 32-bit data-memory words.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 freeze  input  1  hold all state (memory busy / hazard stall).
REQ-006 flush  input  1  load a bubble instead of the incoming instruction.
REQ-007 WB_EN_in, Mem_R_EN_in, Mem_W_EN_in  input  1 each  control from EXE stage.
REQ-008 ALU_res_in  input  32  computed byte address or ALU result.
REQ-009 Val_Rm_in  input  32  store data.
REQ-010 Dest_in  input  4  destination register index.
REQ-011 fault_clr  input  1  synchronous clear of sticky fault state.
REQ-012 WB_EN, Mem_R_EN, Mem_W_EN  output  1 each  registered control to MEM stage.
REQ-013 ALU_res, Val_Rm  output  32 each  registered operands to MEM stage.
REQ-014 Dest  output  4  registered destination.
REQ-015 valid  output  1  1 = registered slot holds a real instruction.
REQ-016 mem_fault  output  1  sticky flag: a memory access was suppressed.
REQ-017 fault_addr  output  32  ALU_res_in of the first suppressed access since last clear.
REQ-018 mem_ops  output  16  count of memory instructions passed to MEM stage.

Function
REQ-019 Latency: one cycle; values on *_in at edge N appear on outputs after edge N, registered only, no combinational input-to-output path.
REQ-020 Precedence per edge: freeze=1 -> all outputs and counters hold, flush and fault_clr ignored; else flush=1 -> bubble; else normal load.
REQ-021 Bubble: WB_EN, Mem_R_EN, Mem_W_EN, valid = 0; ALU_res, Val_Rm = 0; Dest = 0; mem_ops, mem_fault, fault_addr unchanged.
REQ-022 Normal load: ALU_res, Val_Rm, Dest copied; valid = 1; controls copied unless REQ-024 applies.
REQ-023 Access is illegal when (Mem_R_EN_in or Mem_W_EN_in) = 1 and any of: ALU_res_in < DM_BASE; ALU_res_in >= DM_BASE + 4*DM_WORDS; ALU_res_in[1:0] != 0.
REQ-024 Illegal access on normal load: Mem_R_EN, Mem_W_EN forced 0; WB_EN forced 0 if Mem_R_EN_in = 1, else copied; valid = 1; mem_ops not incremented.
REQ-025 Illegal access with mem_fault = 0: mem_fault set 1, fault_addr <= ALU_res_in; with mem_fault = 1: fault_addr unchanged.
REQ-026 fault_clr = 1 (not frozen) clears mem_fault and fault_addr to 0; same-edge illegal access wins: mem_fault = 1, fault_addr = new address.
REQ-027 Legal access on normal load (Mem_R_EN_in or Mem_W_EN_in = 1): mem_ops increments by 1, saturating at 16'hFFFF.
REQ-028 Mem_R_EN_in and Mem_W_EN_in both 1 is treated as illegal regardless of address.
REQ-029 Address arithmetic is 32-bit unsigned; DM_BASE + 4*DM_WORDS computed without overflow at elaboration.

Reset
REQ-030 rst = 0 asynchronously forces all outputs to 0 (valid = 0, mem_fault = 0, fault_addr = 0, mem_ops = 0), independent of clk.
REQ-031 While rst = 0 all inputs ignored; first update on first rising clk edge after rst returns to 1.
REQ-032 Reset asserted mid-freeze or mid-flush discards held state; no state survives reset.

Verification
REQ-033 Load: Mem_R_EN_in=1, WB_EN_in=1, ALU_res_in=1032, Dest_in=5 -> next cycle Mem_R_EN=1, WB_EN=1, ALU_res=1032, Dest=5, valid=1, mem_ops=1.
REQ-034 Freeze: hold freeze=1 for 3 cycles with changing inputs -> outputs identical to pre-freeze values; flush=1 during freeze ignored.
REQ-035 Faults: store to 1026 -> Mem_W_EN=0, mem_fault=1, fault_addr=1026; then load to 1000 -> Mem_R_EN=0, WB_EN=0, fault_addr stays 1026; then fault_clr with store to 2000 (DM_WORDS=64) -> mem_fault=1, fault_addr=2000.
REQ-036 Boundaries: store to 1024 and 1276 legal (mem_ops +2); store to 1280 illegal; Mem_R_EN_in=Mem_W_EN_in=1 at 1024 illegal.
REQ-037 Flush: flush=1 with legal store at 1028 -> all controls 0, valid=0, mem_ops unchanged.
REQ-038 Async reset: drop rst mid-cycle with mem_ops=7, mem_fault=1 -> all outputs 0 before next clk edge.
